spi_flash_reader: RTL and testbench
===================================

Name: spi_flash_reader

Overview:
- SPI bus initiator that issues a flash READ (0x03), sends a 24-bit address, and clocks back N data bytes.
- It drives the opposite end of the bus from the flash emulator.
- Used by the host side (test harness, bootloader fetch, loopback against the emulator) to pull images out of real or emulated SPI flash.
- Bus is SPI mode 0, MSB first. Fabric-side interface is a simple start/strobe handshake.

Parameters:
- CLK_DIV, 2, clk cycles per SCK half-period; legal range 1..255.
- LEN_BITS, 16, width of the requested byte count.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle request; sampled only while busy=0
- addr  input  24  flash start address, latched on accepted start
- len  input  LEN_BITS  data bytes to read, latched on accepted start
- abort  input  1  terminate the transaction immediately
- busy  output  1  high from the accepted start until the end of CS idle time
- done  output  1  one-cycle pulse on normal completion
- rx_data  output  8  last received data byte
- rx_strobe  output  1  one-cycle pulse; rx_data is valid in that cycle
- spi_cs  output  1  chip select, active low (high = deselected)
- spi_sck  output  1  SPI clock, idle low
- spi_mosi  output  1  serial data to flash
- spi_miso  input  1  serial data from flash

Behaviour:
- Reset (async, active-high) values: spi_cs=1, spi_sck=0, spi_mosi=0, busy=0, done=0, rx_strobe=0, rx_data=0x00, state=IDLE.
- IDLE: start=1 latches addr and len, sets busy=1 on the next edge, drives spi_cs=0, and enters CS_SETUP. start while busy=1 is ignored.
- CS_SETUP: holds CLK_DIV cycles with SCK low. MOSI is pre-loaded with bit 7 of the command byte.
- SHIFT: byte sequence is 0x03, addr[23:16], addr[15:8], addr[7:0], then len data bytes.
  - Each bit takes CLK_DIV cycles SCK-low then CLK_DIV cycles SCK-high.
  - MISO is sampled on the clk edge where SCK rises.
  - MOSI updates on the edge where SCK falls, to the next bit.
  - During data bytes MOSI is driven 0.
- Data bytes:
  - The 8th sample of each data byte loads rx_data.
  - rx_strobe pulses in the same cycle rx_data changes, one clk after the 8th rising SCK.
  - No strobe is issued for the command or address bytes.
- After the final falling SCK, CS_HOLD keeps spi_cs=0 for CLK_DIV cycles. Then spi_cs=1 and done pulses in that cycle.
- CS_IDLE: spi_cs stays high for CLK_DIV cycles with busy=1. busy then drops and the block returns to IDLE.
  - Back-to-back reads therefore have a minimum CS-high time of CLK_DIV cycles.
- len=0: command and address only (32 SCK rising edges), no rx_strobe, then the normal CS_HOLD/done sequence.
- Total SCK rising edges per transaction: 8*(4+len).
- Byte counter is LEN_BITS wide. len=2^LEN_BITS-1 must complete without wrap. The address is not incremented locally; the flash auto-increments.
- abort (any non-IDLE state), on the next edge:
  - spi_cs=1, spi_sck=0, spi_mosi=0, no done.
  - Enters CS_IDLE so the CS-high time is honoured.
  - A byte in flight produces no rx_strobe.
  - abort in IDLE has no effect. abort and start in the same IDLE cycle: abort wins, and start is dropped.
- Async reset mid-transaction releases CS within the same cycle (spi_cs=1 asynchronously). No done.
- All outputs are registered; spi_sck never glitches.

Optional Feature:
- FAST_READ_EN defined:
  - The command byte is 0x0B.
  - One dummy byte (MOSI=0, no rx_strobe) is clocked after the address, before the data.
  - Total rising edges: 8*(5+len).
- FAST_READ_EN undefined: only 0x03 is issued and the dummy-byte logic is absent.

Test Plan:
- CLK_DIV=2, start with addr=0x123456, len=2, flash model returns 0xA5,0x3C:
  - MOSI bytes 03 12 34 56 00 00.
  - rx_strobe twice with rx_data 0xA5 then 0x3C.
  - 48 SCK rising edges; done once; busy low 2 cycles after spi_cs rises.
- len=0, addr=0xFFFFFF: 32 SCK edges, zero rx_strobe, done pulses, spi_cs low for exactly 4+32*4+2 cycles (CLK_DIV=2).
- Abort after 20 SCK rising edges of a len=4 read:
  - spi_cs=1 and spi_sck=0 next cycle; no done; no rx_strobe.
  - A new start issued 1 cycle later is ignored; the next start is accepted after busy falls.
- Start asserted while busy plus a second start immediately after done: the first is ignored; the second begins only after the 2-cycle CS_IDLE (CLK_DIV=2).
- Async reset pulsed mid data byte (not aligned to clk): spi_cs goes high without waiting for a clock; all outputs take their reset values; a following read of len=1 works.
- FAST_READ_EN build, addr=0x000100, len=1: MOSI bytes 0B 00 01 00 00 00, 48 rising edges, one rx_strobe.

Source files
------------

// File: rtl/spi_flash_reader_if.sv
// spi_flash_reader_if: fabric start/strobe handshake plus SPI pins of spi_flash_reader.
// master is the initiator (the reader itself); slave is the host/flash side.
interface spi_flash_reader_if #(parameter int LEN_BITS = 16);
   logic                start, abort, busy, done, rx_strobe;
   logic [23:0]         addr;
   logic [LEN_BITS-1:0] len;
   logic [7:0]          rx_data;
   logic                spi_cs, spi_sck, spi_mosi, spi_miso;
   modport master (
      input  start, addr, len, abort, spi_miso,
      output busy, done, rx_data, rx_strobe, spi_cs, spi_sck, spi_mosi
   );
   modport slave (
      output start, addr, len, abort, spi_miso,
      input  busy, done, rx_data, rx_strobe, spi_cs, spi_sck, spi_mosi
   );
endinterface

// File: rtl/spi_flash_reader.sv
// spi_flash_reader: SPI mode-0 initiator issuing READ 0x03 + 24-bit address, then clocking in len bytes.
// Define FAST_READ_EN to issue FAST_READ 0x0B with one dummy byte before the data.
module spi_flash_reader #(
   parameter int CLK_DIV  = 2,
   parameter int LEN_BITS = 16
) (
   input logic                clk,
   input logic                reset,
   spi_flash_reader_if.master bus
);
`ifdef FAST_READ_EN
   localparam logic [7:0] CMD       = 8'h0B;
   localparam logic [2:0] HDR_BYTES = 3'd5;
`else
   localparam logic [7:0] CMD       = 8'h03;
   localparam logic [2:0] HDR_BYTES = 3'd4;
`endif
   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
   typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, CS_IDLE} state_t;
   state_t              state_q, state_d;
   logic [7:0]          cnt_q, cnt_d;
   logic [2:0]          bit_q, bit_d, hdr_q, hdr_d;
   logic [LEN_BITS-1:0] len_q, len_d;
   logic [31:0]         tx_q, tx_d;
   logic [7:0]          rx_sr_q, rx_sr_d, rx_data_q, rx_data_d;
   logic                pend_q, pend_d, rx_strobe_q, rx_strobe_d, done_q, done_d, busy_q, busy_d;
   logic                cs_q, cs_d, sck_q, sck_d, mosi_q, mosi_d;
   logic                ph_end;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         bit_q       <= '0;
         hdr_q       <= '0;
         len_q       <= '0;
         tx_q        <= '0;
         rx_sr_q     <= '0;
         rx_data_q   <= '0;
         pend_q      <= 1'b0;
         rx_strobe_q <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         cs_q        <= 1'b1;
         sck_q       <= 1'b0;
         mosi_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         hdr_q       <= hdr_d;
         len_q       <= len_d;
         tx_q        <= tx_d;
         rx_sr_q     <= rx_sr_d;
         rx_data_q   <= rx_data_d;
         pend_q      <= pend_d;
         rx_strobe_q <= rx_strobe_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
         cs_q        <= cs_d;
         sck_q       <= sck_d;
         mosi_q      <= mosi_d;
      end
   end
   always_comb begin
      state_d     = state_q;
      cnt_d       = '0;
      bit_d       = bit_q;
      hdr_d       = hdr_q;
      len_d       = len_q;
      tx_d        = tx_q;
      rx_sr_d     = rx_sr_q;
      rx_data_d   = pend_q ? rx_sr_q : rx_data_q;
      rx_strobe_d = pend_q;
      pend_d      = 1'b0;
      done_d      = 1'b0;
      busy_d      = busy_q;
      cs_d        = cs_q;
      sck_d       = sck_q;
      mosi_d      = mosi_q;
      ph_end      = cnt_q == DIV_LAST;
      if (state_q != IDLE) cnt_d = ph_end ? 8'd0 : cnt_q + 8'd1;
      case (state_q)
         IDLE: if (bus.start && !bus.abort) begin
            state_d = CS_SETUP;
            busy_d  = 1'b1;
            cs_d    = 1'b0;
            mosi_d  = CMD[7];
            tx_d    = {CMD[6:0], bus.addr, 1'b0};
            hdr_d   = HDR_BYTES;
            len_d   = bus.len;
            bit_d   = '0;
         end
         CS_SETUP: if (ph_end) state_d = SHIFT;
         // a low half-period whose bit slot is past the end leads into CS_HOLD instead of rising
         SHIFT: if (ph_end) begin
            if (!sck_q) begin
               if (hdr_q == 3'd0 && len_q == '0) state_d = CS_HOLD;
               else begin
                  sck_d   = 1'b1;
                  rx_sr_d = {rx_sr_q[6:0], bus.spi_miso};
                  pend_d  = hdr_q == 3'd0 && bit_q == 3'd7;
               end
            end else begin
               sck_d  = 1'b0;
               mosi_d = tx_q[31];
               tx_d   = tx_q << 1;
               bit_d  = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  hdr_d = hdr_q != 3'd0 ? hdr_q - 3'd1 : hdr_q;
                  len_d = hdr_q == 3'd0 ? len_q - LEN_BITS'(1) : len_q;
               end
            end
         end
         CS_HOLD: if (ph_end) begin
            state_d = CS_IDLE;
            cs_d    = 1'b1;
            done_d  = 1'b1;
         end
         CS_IDLE: if (ph_end) begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: state_d = IDLE;
      endcase
      if (bus.abort && state_q != IDLE) begin
         state_d     = CS_IDLE;
         cnt_d       = '0;
         cs_d        = 1'b1;
         sck_d       = 1'b0;
         mosi_d      = 1'b0;
         busy_d      = 1'b1;
         done_d      = 1'b0;
         pend_d      = 1'b0;
         rx_strobe_d = 1'b0;
         rx_data_d   = rx_data_q;
      end
   end
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.rx_data   = rx_data_q;
   assign bus.rx_strobe = rx_strobe_q;
   assign bus.spi_cs    = cs_q;
   assign bus.spi_sck   = sck_q;
   assign bus.spi_mosi  = mosi_q;
endmodule

// File: tb/tb_spi_flash_reader.sv
// tb_spi_flash_reader: directed reads against a small mode-0 flash model with hand-computed expectations.
module tb_spi_flash_reader;
   localparam int CLK_DIV = 2;
`ifdef FAST_READ_EN
   localparam int         HDR = 5;
   localparam logic [7:0] CMD = 8'h0B;
`else
   localparam int         HDR = 4;
   localparam logic [7:0] CMD = 8'h03;
`endif
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   int         n_checks = 0;
   int         n_errors = 0;
   logic [7:0] fdata [4] = '{8'hA5, 8'h3C, 8'h5A, 8'h81};
   logic [7:0] mosi_q [$];
   logic [7:0] rx_q [$];
   int         rise_txn = 0, fall_txn = 0, cs_low_txn = 0, done_txn = 0;
   logic       cs_prev = 1'b1, sck_prev = 1'b0;
   logic [7:0] acc = '0;
   int         n, gap, b1;

   spi_flash_reader_if #(.LEN_BITS(16)) bus ();
   spi_flash_reader #(.CLK_DIV(CLK_DIV), .LEN_BITS(16)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   // flash model + bus monitor: MISO shifts out on falling SCK, per-transaction logs restart on CS fall
   always @(negedge clk) begin : mon
      int idx;
      if (cs_prev && !bus.spi_cs) begin
         rise_txn = 0; fall_txn = 0; cs_low_txn = 0; done_txn = 0;
         mosi_q.delete(); rx_q.delete(); acc = '0;
         bus.spi_miso = 1'b0;
      end
      if (!bus.spi_cs) cs_low_txn++;
      if (!sck_prev && bus.spi_sck) begin
         rise_txn++;
         acc = {acc[6:0], bus.spi_mosi};
         if (rise_txn % 8 == 0) mosi_q.push_back(acc);
      end
      if (sck_prev && !bus.spi_sck) begin
         fall_txn++;
         idx = fall_txn - HDR * 8;
         bus.spi_miso = (idx >= 0 && idx / 8 < 4) ? fdata[idx / 8][7 - idx % 8] : 1'b0;
      end
      if (bus.rx_strobe) rx_q.push_back(bus.rx_data);
      if (bus.done) done_txn++;
      cs_prev  = bus.spi_cs;
      sck_prev = bus.spi_sck;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   function automatic logic [7:0] exp_mosi(input logic [23:0] a, input int i);
      return i == 0 ? CMD : i == 1 ? a[23:16] : i == 2 ? a[15:8] : i == 3 ? a[7:0] : 8'h00;
   endfunction

   task automatic start_read(input logic [23:0] a, input logic [15:0] l);
      bus.addr  = a;
      bus.len   = l;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic finish_read(output int g);
      int k;
      k = 0;
      while (!bus.spi_cs && k < 5000) begin tick(); k++; end
      g = 0;
      while (bus.busy && g < 50) begin tick(); g++; end
      check("busy_clear", 32'(bus.busy), 32'd0);
   endtask

   task automatic check_txn(input logic [23:0] a, input int l);
      check("rises", 32'(rise_txn), 32'(8 * (HDR + l)));
      check("mosi_bytes", 32'(mosi_q.size()), 32'(HDR + l));
      for (int i = 0; i < mosi_q.size(); i++) check($sformatf("mosi%0d", i), 32'(mosi_q[i]), 32'(exp_mosi(a, i)));
      check("strobes", 32'(rx_q.size()), 32'(l));
      for (int i = 0; i < rx_q.size() && i < 4; i++) check($sformatf("rx%0d", i), 32'(rx_q[i]), 32'(fdata[i]));
      check("done_cnt", 32'(done_txn), 32'd1);
      check("cs_low", 32'(cs_low_txn), 32'(CLK_DIV + 8 * (HDR + l) * 2 * CLK_DIV + 2 * CLK_DIV));
   endtask

   initial begin
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.addr  = '0;
      bus.len   = '0;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      check("reset_state", 32'({bus.spi_cs, bus.spi_sck, bus.spi_mosi, bus.busy, bus.done, bus.rx_strobe, bus.rx_data}), 32'h2000);

      // basic read: 03 12 34 56 + two data bytes A5 3C
      start_read(24'h123456, 16'd2);
      check("busy_on_start", 32'(bus.busy), 32'd1);
      finish_read(gap);
      check_txn(24'h123456, 2);
      check("t1_busy_gap", 32'(gap), 32'd2);
      check("t1_rx_last", 32'(bus.rx_data), 32'h3C);

      // len=0: header only, 134 CS-low cycles in the non-fast build
      start_read(24'hFFFFFF, 16'd0);
      finish_read(gap);
      check_txn(24'hFFFFFF, 0);
      check("t2_busy_gap", 32'(gap), 32'd2);

      // abort after 20 rising edges, then a start inside CS_IDLE must be dropped
      start_read(24'h000010, 16'd4);
      for (n = 0; rise_txn < 20 && n < 500; n++) tick();
      check("t3_rise20", 32'(rise_txn), 32'd20);
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      check("t3_abort_pins", 32'({bus.spi_cs, bus.spi_sck, bus.spi_mosi, bus.busy}), 32'b1001);
      bus.addr  = 24'h000777;
      bus.len   = 16'd1;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      finish_read(gap);
      repeat (3) tick();
      check("t3_ignored", 32'({bus.spi_cs, bus.busy}), 32'b10);
      check("t3_rises", 32'(rise_txn), 32'd20);
      check("t3_no_done", 32'(done_txn), 32'd0);
      check("t3_no_strobe", 32'(rx_q.size()), 32'd0);
      start_read(24'h000100, 16'd1);
      finish_read(gap);
      check_txn(24'h000100, 1);

      // start while busy is ignored; start held from the done cycle waits out CS_IDLE
      start_read(24'h00ABCD, 16'd1);
      repeat (3) tick();
      bus.addr  = 24'h111111;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (n = 0; !bus.done && n < 2000; n++) tick();
      check("t4_done_seen", 32'(bus.done), 32'd1);
      check_txn(24'h00ABCD, 1);
      bus.addr  = 24'h222222;
      bus.len   = 16'd1;
      bus.start = 1'b1;
      n  = 0;
      b1 = 0;
      do begin
         tick();
         n++;
         if (n == 1) b1 = 32'(bus.busy);
      end while (bus.spi_cs && n < 20);
      bus.start = 1'b0;
      check("t4_idle_busy", 32'(b1), 32'd1);
      check("t4_cs_high", 32'(n), 32'd3);
      finish_read(gap);
      check_txn(24'h222222, 1);
      check("t4_busy_gap", 32'(gap), 32'd2);

      // async reset in the middle of data byte 0
      start_read(24'h0000FF, 16'd2);
      for (n = 0; rise_txn < 36 && n < 500; n++) tick();
      check("t5_rise36", 32'(rise_txn), 32'd36);
      #2 reset = 1'b1;
      #1;
      check("t5_cs_async", 32'(bus.spi_cs), 32'd1);
      check("t5_rst_state", 32'({bus.spi_cs, bus.spi_sck, bus.spi_mosi, bus.busy, bus.done, bus.rx_strobe, bus.rx_data}), 32'h2000);
      #3 reset = 1'b0;
      repeat (2) tick();
      check("t5_no_done", 32'(done_txn), 32'd0);
      check("t5_no_strobe", 32'(rx_q.size()), 32'd0);
      start_read(24'h000042, 16'd1);
      finish_read(gap);
      check_txn(24'h000042, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
